// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned INST_BYTES = 4;
    // addi x0, x0, 0 -- what decode inserts when it needs a bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// Handshake: an entry transfers on any rising edge where out_valid && out_ready;
// out_valid never depends combinationally on out_ready or redirect_*.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic [31:0]            imem_addr;
    logic [31:0]            imem_inst;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_inst;
    logic [31:0]            out_pc;
    logic [31:0]            out_pc_plus4;
    logic [$clog2(DEPTH):0] count;

    modport master (
        input  imem_inst, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, count
    );

    modport slave (
        output imem_inst, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, count
    );
endinterface

// File: rtl/fetch_fifo.sv
// In-order circular buffer of fetched {pc, inst} entries; flush drops all entries
// by resetting the pointers, while reset also clears the storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, captures same-cycle imem data into
// an in-order queue and hands entries to decode; redirect flushes and restarts.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    logic [31:0]  r_fpc;
    fetch_entry_t w_head;
    fetch_entry_t w_wr_data;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;

    assign w_pop     = !w_empty && bus.out_ready;
    // A full queue still accepts a new word when the head leaves the same cycle.
    assign w_push    = !bus.redirect_valid && (!w_full || w_pop);
    assign w_wr_data = '{pc: r_fpc, inst: bus.imem_inst};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_fpc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_fpc <= r_fpc + 32'(INST_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_wr_data),
        .o_head  (w_head),
        .o_count (bus.count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.imem_addr    = r_fpc;
    assign bus.out_valid    = !w_empty;
    assign bus.out_inst     = w_head.inst;
    assign bus.out_pc       = w_head.pc;
    assign bus.out_pc_plus4 = w_head.pc + 32'(INST_BYTES);

endmodule
